// File: rtl/lock_pkg.sv
// Shared state type, default parameters and timer sizing for the code lock.
// Latency: none (types, constants and a constant function only).
// Backpressure: none.
package lock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTRY   = 2'd1,
        ST_OPEN    = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    localparam int             DEF_SYMBOL_W       = 3;
    localparam int             DEF_CODE_LEN       = 3;
    localparam logic [8:0]     DEF_RESET_CODE     = 9'b101_111_011;
    localparam int             DEF_UNLOCK_CYCLES  = 8;
    localparam int             DEF_MAX_FAILS      = 3;
    localparam int             DEF_LOCKOUT_CYCLES = 16;
    localparam int             DEF_TIMEOUT_CYCLES = 32;

    // The shared timer must hold the longest of the three durations.
    function automatic int timer_width(input int unlock_cycles,
                                       input int lockout_cycles,
                                       input int timeout_cycles);
        int longest;
        longest = unlock_cycles;
        if (lockout_cycles > longest) longest = lockout_cycles;
        if (timeout_cycles > longest) longest = timeout_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the unlock, lockout and entry-timeout windows.
// Latency: done is high during the cycle whose closing edge takes the count from 1 to 0.
// Backpressure: none; a load always wins over counting and the count rests at zero.
module lock_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] cnt_q;

    // Reload on request, otherwise count down and rest at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= value;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    // The owner gives a reload on the same edge priority over this flag.
    assign done = (cnt_q == W'(1));

endmodule

// File: rtl/code_lock_fsm.sv
// Keyed code lock: full-length entry compare, timed unlock window, fail counting with timed lockout.
// Latency: all outputs registered, changing one edge after the edge that samples the causing input.
// Backpressure: none; x_valid is always taken in IDLE/ENTRY and silently dropped in OPEN/LOCKOUT.
module code_lock_fsm
    import lock_pkg::*;
#(
    parameter int                             SYMBOL_W       = DEF_SYMBOL_W,
    parameter int                             CODE_LEN       = DEF_CODE_LEN,
    parameter logic [SYMBOL_W*CODE_LEN-1:0]   RESET_CODE     = DEF_RESET_CODE,
    parameter int                             UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
    parameter int                             MAX_FAILS      = DEF_MAX_FAILS,
    parameter int                             LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int                             TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [SYMBOL_W-1:0]               x,
    input  logic                              x_valid,
    input  logic                              code_we,
    input  logic [SYMBOL_W*CODE_LEN-1:0]      code_in,
    input  logic                              relock,
    output logic                              y,
    output logic                              locked_out,
    output logic [$clog2(MAX_FAILS+1)-1:0]    fail_count,
    output logic                              entry_busy
);

    localparam int IDX_W = $clog2(CODE_LEN);
    localparam int FC_W  = $clog2(MAX_FAILS + 1);
    localparam int TMR_W = timer_width(UNLOCK_CYCLES, LOCKOUT_CYCLES, TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CODE_LEN - 1);

    state_t                         state_q, state_d;
    logic [SYMBOL_W*CODE_LEN-1:0]   code_q;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic                           mism_q, mism_d;
    logic [FC_W-1:0]                fail_q, fail_d;
    logic                           y_q, lo_q, busy_q;
    logic                           tmr_load;
    logic [TMR_W-1:0]               tmr_val;
    logic                           tmr_done;
    logic [SYMBOL_W-1:0]            sym_sel;
    logic                           sym_miss;

    // Expected symbol for the current position; idx_q is 0 in IDLE so symbol 0 is used there.
    assign sym_sel  = code_q[idx_q*SYMBOL_W +: SYMBOL_W];
    assign sym_miss = (x != sym_sel);

    lock_timer #(.W(TMR_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .value (tmr_val),
        .done  (tmr_done)
    );

    // Next-state, entry bookkeeping and timer reloads; a symbol on the timeout edge beats the timeout.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mism_d   = mism_q;
        fail_d   = fail_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (x_valid) begin
                    state_d  = ST_ENTRY;
                    idx_d    = IDX_W'(1);
                    mism_d   = sym_miss;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(TIMEOUT_CYCLES);
                end
            end
            ST_ENTRY: begin
                if (x_valid) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d  = '0;
                        mism_d = 1'b0;
                        if (!(mism_q || sym_miss)) begin
                            state_d  = ST_OPEN;
                            fail_d   = '0;
                            tmr_load = 1'b1;
                            tmr_val  = TMR_W'(UNLOCK_CYCLES);
                        end else if (fail_q == FC_W'(MAX_FAILS - 1)) begin
                            state_d  = ST_LOCKOUT;
                            fail_d   = FC_W'(MAX_FAILS);
                            tmr_load = 1'b1;
                            tmr_val  = TMR_W'(LOCKOUT_CYCLES);
                        end else begin
                            state_d = ST_IDLE;
                            fail_d  = fail_q + FC_W'(1);
                        end
                    end else begin
                        idx_d    = idx_q + IDX_W'(1);
                        mism_d   = mism_q | sym_miss;
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(TIMEOUT_CYCLES);
                    end
                end else if (tmr_done) begin
                    // Abandoned partial entry: discard it without counting a failure.
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    mism_d  = 1'b0;
                end
            end
            ST_OPEN: begin
                if (relock || tmr_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                if (tmr_done) begin
                    state_d = ST_IDLE;
                    fail_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, entry progress and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            mism_q  <= 1'b0;
            fail_q  <= '0;
            y_q     <= 1'b0;
            lo_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mism_q  <= mism_d;
            fail_q  <= fail_d;
            y_q     <= (state_d == ST_OPEN);
            lo_q    <= (state_d == ST_LOCKOUT);
            busy_q  <= (state_d == ST_ENTRY);
        end
    end

    // Code register: writable only while open, including the edge the open window expires or relocks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            code_q <= RESET_CODE;
        end else if (state_q == ST_OPEN && code_we) begin
            code_q <= code_in;
        end
    end

    assign y          = y_q;
    assign locked_out = lo_q;
    assign fail_count = fail_q;
    assign entry_busy = busy_q;

endmodule

// File: tb/tb_code_lock_fsm.sv
// Bench for code_lock_fsm: vector table, directed corner sequences, then random traffic vs a reference model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: none; stimulus is free-running.
module tb_code_lock_fsm;

    localparam int SW = 3;
    localparam int CL = 3;
    localparam int UC = 8;
    localparam int MF = 3;
    localparam int LC = 16;
    localparam int TC = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  x;
    logic        x_valid;
    logic        code_we;
    logic [8:0]  code_in;
    logic        relock;
    logic        y;
    logic        locked_out;
    logic [1:0]  fail_count;
    logic        entry_busy;

    code_lock_fsm #(
        .SYMBOL_W       (SW),
        .CODE_LEN       (CL),
        .RESET_CODE     (9'b101_111_011),
        .UNLOCK_CYCLES  (UC),
        .MAX_FAILS      (MF),
        .LOCKOUT_CYCLES (LC),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .x_valid    (x_valid),
        .code_we    (code_we),
        .code_in    (code_in),
        .relock     (relock),
        .y          (y),
        .locked_out (locked_out),
        .fail_count (fail_count),
        .entry_busy (entry_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: modes, keyed-symbol queue, absolute deadlines ----------------
    localparam int M_IDLE  = 0;
    localparam int M_ENTRY = 1;
    localparam int M_OPEN  = 2;
    localparam int M_LOCK  = 3;

    int         m_mode;
    int         m_fails;
    int         m_edge;
    int         m_deadline;
    logic [2:0] m_code [CL];
    logic [2:0] m_keyed [$];

    task automatic model_reset();
        logic [8:0] rc;
        rc = 9'b101_111_011;
        for (int i = 0; i < CL; i++) m_code[i] = rc[i*SW +: SW];
        m_keyed.delete();
        m_mode     = M_IDLE;
        m_fails    = 0;
        m_edge     = 0;
        m_deadline = 0;
    endtask

    task automatic model_edge();
        bit ok;
        m_edge++;
        case (m_mode)
            M_IDLE, M_ENTRY: begin
                if (x_valid) begin
                    m_keyed.push_back(x);
                    if (m_keyed.size() == CL) begin
                        ok = 1'b1;
                        for (int i = 0; i < CL; i++) if (m_keyed[i] != m_code[i]) ok = 1'b0;
                        m_keyed.delete();
                        if (ok) begin
                            m_mode = M_OPEN;
                            m_fails = 0;
                            m_deadline = m_edge + UC;
                        end else begin
                            m_fails++;
                            if (m_fails >= MF) begin
                                m_mode = M_LOCK;
                                m_deadline = m_edge + LC;
                            end else begin
                                m_mode = M_IDLE;
                            end
                        end
                    end else begin
                        m_mode = M_ENTRY;
                        m_deadline = m_edge + TC;
                    end
                end else if (m_mode == M_ENTRY && m_edge == m_deadline) begin
                    m_mode = M_IDLE;
                    m_keyed.delete();
                end
            end
            M_OPEN: begin
                if (code_we) for (int i = 0; i < CL; i++) m_code[i] = code_in[i*SW +: SW];
                if (relock || m_edge == m_deadline) m_mode = M_IDLE;
            end
            default: begin
                if (m_edge == m_deadline) begin
                    m_mode = M_IDLE;
                    m_fails = 0;
                end
            end
        endcase
    endtask

    task automatic chk_model();
        check("y", y, int'(m_mode == M_OPEN));
        check("locked_out", locked_out, int'(m_mode == M_LOCK));
        check("fail_count", fail_count, m_fails);
        check("entry_busy", entry_busy, int'(m_mode == M_ENTRY));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic cyc(input bit xv, input logic [2:0] xx, input bit we, input logic [8:0] ci, input bit rl);
        x_valid = xv;
        x       = xx;
        code_we = we;
        code_in = ci;
        relock  = rl;
        tick();
        chk_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 1'b0, 9'd0, 1'b0);
    endtask

    task automatic enter(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        cyc(1'b1, a, 1'b0, 9'd0, 1'b0);
        cyc(1'b1, b, 1'b0, 9'd0, 1'b0);
        cyc(1'b1, c, 1'b0, 9'd0, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        check({tag, "_y"}, y, 0);
        check({tag, "_locked_out"}, locked_out, 0);
        check({tag, "_fail_count"}, fail_count, 0);
        check({tag, "_entry_busy"}, entry_busy, 0);
        model_reset();
        x_valid = 1'b0;
        code_we = 1'b0;
        relock  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit         xv;
        logic [2:0] x;
        bit         ey;
        bit         elo;
        int         efc;
        bit         eb;
    } vec_t;

    vec_t tv [14];

    initial begin
        int lo_cnt;
        int pct;
        reset   = 1'b1;
        x       = '0;
        x_valid = 1'b0;
        code_we = 1'b0;
        code_in = '0;
        relock  = 1'b0;

        tv[0]  = '{1'b1, 3'd3, 1'b0, 1'b0, 0, 1'b1};
        tv[1]  = '{1'b1, 3'd7, 1'b0, 1'b0, 0, 1'b1};
        tv[2]  = '{1'b1, 3'd5, 1'b1, 1'b0, 0, 1'b0};
        for (int i = 3; i <= 9; i++) tv[i] = '{1'b0, 3'd0, 1'b1, 1'b0, 0, 1'b0};
        tv[10] = '{1'b0, 3'd0, 1'b0, 1'b0, 0, 1'b0};
        tv[11] = '{1'b1, 3'd3, 1'b0, 1'b0, 0, 1'b1};
        tv[12] = '{1'b1, 3'd0, 1'b0, 1'b0, 0, 1'b1};
        tv[13] = '{1'b1, 3'd5, 1'b0, 1'b0, 1, 1'b0};

        #2;
        do_reset("por");

        // Correct unlock, 8-cycle window, then one failed entry.
        for (int i = 0; i < 14; i++) begin
            x_valid = tv[i].xv;
            x       = tv[i].x;
            code_we = 1'b0;
            relock  = 1'b0;
            tick();
            check($sformatf("tv%0d_y", i), y, tv[i].ey);
            check($sformatf("tv%0d_locked_out", i), locked_out, tv[i].elo);
            check($sformatf("tv%0d_fail_count", i), fail_count, tv[i].efc);
            check($sformatf("tv%0d_entry_busy", i), entry_busy, tv[i].eb);
        end

        // Two more failures reach lockout; symbols and code writes during lockout are ignored.
        enter(3'd3, 3'd0, 3'd5);
        enter(3'd3, 3'd0, 3'd5);
        check("lockout_entered", locked_out, 1);
        lo_cnt = int'(locked_out);
        for (int i = 0; i < LC; i++) begin
            cyc(1'b1, 3'd3, 1'b1, 9'd0, 1'b0);
            lo_cnt += int'(locked_out);
        end
        check("lockout_len", lo_cnt, LC);
        check("lockout_fc_cleared", fail_count, 0);
        idle(1);
        enter(3'd3, 3'd7, 3'd5);
        check("code_kept_after_lock_we", y, 1);

        // Reprogram and relock on the same edge, then use the new code; the old one fails.
        cyc(1'b0, 3'd0, 1'b1, 9'b001_010_100, 1'b1);
        check("relock_y", y, 0);
        enter(3'd4, 3'd2, 3'd1);
        check("new_code_unlocks", y, 1);
        idle(UC + 1);
        enter(3'd3, 3'd7, 3'd5);
        check("old_code_rejected_y", y, 0);
        check("old_code_rejected_fc", fail_count, 1);

        // Reset during OPEN restores the reset code.
        enter(3'd4, 3'd2, 3'd1);
        check("open_before_reset", y, 1);
        do_reset("rst_open");
        enter(3'd3, 3'd7, 3'd5);
        check("code_reverted", y, 1);
        idle(UC + 1);

        // Reset during LOCKOUT.
        enter(3'd3, 3'd0, 3'd5);
        enter(3'd3, 3'd0, 3'd5);
        enter(3'd3, 3'd0, 3'd5);
        check("lock_before_reset", locked_out, 1);
        idle(3);
        do_reset("rst_lock");

        // Partial entry timeout keeps the fail count.
        enter(3'd3, 3'd0, 3'd5);
        cyc(1'b1, 3'd3, 1'b0, 9'd0, 1'b0);
        cyc(1'b1, 3'd7, 1'b0, 9'd0, 1'b0);
        idle(TC - 1);
        check("timeout_busy_before", entry_busy, 1);
        idle(1);
        check("timeout_busy_after", entry_busy, 0);
        check("timeout_fc_kept", fail_count, 1);
        enter(3'd3, 3'd7, 3'd5);
        check("unlock_after_timeout", y, 1);
        idle(UC + 1);

        // A symbol on the timeout edge is accepted.
        cyc(1'b1, 3'd3, 1'b0, 9'd0, 1'b0);
        idle(TC - 1);
        cyc(1'b1, 3'd7, 1'b0, 9'd0, 1'b0);
        check("timeout_edge_symbol_busy", entry_busy, 1);
        cyc(1'b1, 3'd5, 1'b0, 9'd0, 1'b0);
        check("timeout_edge_symbol_unlock", y, 1);
        idle(UC + 1);

        // code_we in IDLE is ignored.
        cyc(1'b0, 3'd0, 1'b1, 9'd0, 1'b0);
        enter(3'd3, 3'd7, 3'd5);
        check("idle_we_ignored", y, 1);
        idle(UC + 1);

        // Random traffic against the model, with changing symbol density.
        for (int n = 0; n < 4000; n++) begin
            logic [2:0] xs;
            int k;
            case ((n / 250) % 3)
                0:       pct = 60;
                1:       pct = 15;
                default: pct = 2;
            endcase
            if ($urandom_range(0, 499) == 0) begin
                do_reset("rnd_rst");
            end else begin
                k = m_keyed.size();
                if (k < CL && $urandom_range(0, 3) != 0) xs = m_code[k];
                else xs = 3'($urandom_range(0, 7));
                cyc($urandom_range(0, 99) < pct, xs, $urandom_range(0, 7) == 0,
                    9'($urandom_range(0, 511)), $urandom_range(0, 15) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
